// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts tagged read/write requests over val/rdy,
// returns responses through a small FIFO, with per-side minimum handshake intervals.
module mem_responder #(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_addr_words      = 256,
  parameter int unsigned p_queue_depth     = 2,
  parameter int unsigned p_recv_intv_delay = 1,
  parameter int unsigned p_send_intv_delay = 1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   init_en,
  input  logic [31:0]            init_addr,
  input  logic [31:0]            init_data,

  input  logic                   recv_val,
  output logic                   recv_rdy,
  input  logic                   recv_op,
  input  logic [p_opaq_bits-1:0] recv_opaque,
  input  logic [31:0]            recv_addr,
  input  logic [31:0]            recv_data,

  output logic                   send_val,
  input  logic                   send_rdy,
  output logic                   send_op,
  output logic [p_opaq_bits-1:0] send_opaque,
  output logic [31:0]            send_data
);

  localparam int unsigned AW  = $clog2(p_addr_words);
  localparam int unsigned EW  = 1 + p_opaq_bits + 32;
  localparam int unsigned PW  = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
  localparam int unsigned CW  = $clog2(p_queue_depth + 1);
  localparam int unsigned RCW = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1;
  localparam int unsigned SCW = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1;

  localparam logic [RCW-1:0] RecvLoad  = RCW'(p_recv_intv_delay - 1);
  localparam logic [SCW-1:0] SendLoad  = SCW'(p_send_intv_delay - 1);
  localparam logic [PW-1:0]  PtrLast   = PW'(p_queue_depth - 1);
  localparam logic [CW-1:0]  CountFull = CW'(p_queue_depth);

  logic [31:0]    mem [p_addr_words];
  logic [EW-1:0]  queue_q [p_queue_depth];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [RCW-1:0] recv_cnt_q;
  logic [SCW-1:0] send_cnt_q;

  logic [AW-1:0]  recv_idx, init_idx;
  logic           full, empty, recv_go, send_go;
  logic           unused_addr_bits;

  // Upper address bits and byte offset are ignored so addresses wrap.
  assign recv_idx = recv_addr[2 +: AW];
  assign init_idx = init_addr[2 +: AW];
  assign unused_addr_bits = ^{recv_addr[31:2+AW], recv_addr[1:0],
                              init_addr[31:2+AW], init_addr[1:0]};

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  assign recv_rdy = !full && (recv_cnt_q == '0) && !rst;
  assign send_val = !empty && (send_cnt_q == '0) && !rst;

  assign recv_go = recv_val && recv_rdy;
  assign send_go = send_val && send_rdy;

  assign {send_op, send_opaque, send_data} = queue_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + PW'(1);
  endfunction

  // Request write is the later assignment so it overrides a colliding backdoor write.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_idx] <= init_data;
    end
    if (recv_go && recv_op) begin
      mem[recv_idx] <= recv_data;
    end
  end

  always_ff @(posedge clk) begin
    if (recv_go) begin
      queue_q[wr_ptr_q] <= {recv_op, recv_opaque, recv_op ? 32'd0 : mem[recv_idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      recv_cnt_q <= '0;
      send_cnt_q <= '0;
    end else begin
      if (recv_go) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (send_go) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case ({recv_go, send_go})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (recv_go) begin
        recv_cnt_q <= RecvLoad;
      end else if (recv_cnt_q != '0) begin
        recv_cnt_q <= recv_cnt_q - RCW'(1);
      end

      if (send_go) begin
        send_cnt_q <= SendLoad;
      end else if (send_cnt_q != '0) begin
        send_cnt_q <= send_cnt_q - SCW'(1);
      end
    end
  end

endmodule
